// File: rtl/count_stream_checker_if.sv
// Producer-to-checker count stream: valid/data from the producer, ready back.
interface count_stream_checker_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;

   // Producer side of the stream.
   modport master (
      output in_valid,
      output in_data,
      input  in_ready
   );

   // Checker side of the stream.
   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready
   );
endinterface

// File: rtl/count_stream_checker.sv
// Checks that an incoming count stream advances by +1 (mod 2^WIDTH) per beat.
// Locks after LOCK_N consecutive in-sequence beats, then counts matches and
// sequence breaks and records the expected/received values of the last break.
module count_stream_checker #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned LOCK_N = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic                        stall,
   count_stream_checker_if.slave       stream,
   output logic                        locked,
   output logic [15:0]                 match_count,
   output logic [7:0]                  err_count,
   output logic                        err_pulse,
   output logic [WIDTH-1:0]            err_exp,
   output logic [WIDTH-1:0]            err_got
);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKING  = 2'd1,
      LOCKED   = 2'd2
   } state_t;

   // run+1 == LOCK_N is evaluated as run >= LOCK_N-1 so the 8-bit run
   // counter never needs a ninth bit; LOCK_N == 1 locks on the first beat.
   localparam logic [7:0] LOCK_LAST = 8'(LOCK_N - 1);
   localparam bit         LOCK_ONE  = (LOCK_N == 1);

   state_t           state_q, state_d;
   logic [7:0]       run_q, run_d;
   logic [WIDTH-1:0] expected_q, expected_d;
   logic [15:0]      match_q, match_d;
   logic [7:0]       err_cnt_q, err_cnt_d;
   logic             err_pulse_q, err_pulse_d;
   logic [WIDTH-1:0] err_exp_q, err_exp_d;
   logic [WIDTH-1:0] err_got_q, err_got_d;
   logic             locked_q;

   logic             accept;
   logic             in_seq;
   logic [WIDTH-1:0] data_inc;

   // Back-pressure: clear also blocks acceptance so it wins over any beat.
   always_comb begin
      stream.in_ready = ~stall & ~clear;
   end

   // Beat qualification and sequence comparison.
   always_comb begin
      accept   = stream.in_valid & ~stall & ~clear;
      in_seq   = (stream.in_data == expected_q);
      data_inc = stream.in_data + WIDTH'(1);
   end

   // Next-state and datapath update for an accepted beat; idle cycles hold.
   always_comb begin
      state_d     = state_q;
      run_d       = run_q;
      expected_d  = expected_q;
      match_d     = match_q;
      err_cnt_d   = err_cnt_q;
      err_pulse_d = 1'b0;
      err_exp_d   = err_exp_q;
      err_got_d   = err_got_q;

      if (accept) begin
         expected_d = data_inc;
         case (state_q)
            UNLOCKED: begin
               run_d   = 8'd1;
               state_d = LOCK_ONE ? LOCKED : LOCKING;
            end
            LOCKING: begin
               if (in_seq) begin
                  run_d = run_q + 8'd1;
                  if (run_q >= LOCK_LAST) begin
                     state_d = LOCKED;
                  end
               end else begin
                  run_d = 8'd1;
               end
            end
            LOCKED: begin
               if (in_seq) begin
                  if (match_q != '1) begin
                     match_d = match_q + 16'd1;
                  end
               end else begin
                  if (err_cnt_q != '1) begin
                     err_cnt_d = err_cnt_q + 8'd1;
                  end
                  err_exp_d   = expected_q;
                  err_got_d   = stream.in_data;
                  err_pulse_d = 1'b1;
                  run_d       = 8'd1;
                  state_d     = LOCKING;
               end
            end
            default: begin
               state_d = UNLOCKED;
            end
         endcase
      end
   end

   // State and status registers; rst and clear both return to the idle state.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q     <= UNLOCKED;
         run_q       <= '0;
         expected_q  <= '0;
         match_q     <= '0;
         err_cnt_q   <= '0;
         err_pulse_q <= 1'b0;
         err_exp_q   <= '0;
         err_got_q   <= '0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         run_q       <= run_d;
         expected_q  <= expected_d;
         match_q     <= match_d;
         err_cnt_q   <= err_cnt_d;
         err_pulse_q <= err_pulse_d;
         err_exp_q   <= err_exp_d;
         err_got_q   <= err_got_d;
         locked_q    <= (state_d == LOCKED);
      end
   end

   // Registered status outputs.
   always_comb begin
      locked      = locked_q;
      match_count = match_q;
      err_count   = err_cnt_q;
      err_pulse   = err_pulse_q;
      err_exp     = err_exp_q;
      err_got     = err_got_q;
   end

endmodule
